// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to
// instruction memory and hands the fetched word plus its PC to decode.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   imem_req_*        fetch request channel (valid/ready, addr = pc)
//   imem_rsp_*        fetch response (one-cycle valid pulse + data)
//   inst_valid/ready  handshake towards decode
//   inst_o, inst_addr instruction word and its PC
//   jump_en/addr      redirect from execute, sampled on the inst handshake
//   fetch_err         sticky error after a misaligned next PC
module ysyx_23060332_ifu #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              fetch_err
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic [ADDR_W-1:0] nxt_pc;

  // Candidate next PC; only consumed on the decode handshake.
  assign nxt_pc = jump_en ? jump_addr : pc_q + PC_STEP;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      inst_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Responses are only accepted here, so stale ones are dropped.
        if (imem_rsp_valid) begin
          inst_d      = imem_rsp_data;
          inst_addr_d = pc_q;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          // A misaligned target freezes the PC and parks the unit in ERR.
          if (nxt_pc[1:0] != 2'b00) begin
            state_d = S_ERR;
          end else begin
            pc_d    = nxt_pc;
            state_d = S_REQ;
          end
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    fetch_err      = 1'b0;
    unique case (state_q)
      S_REQ:   imem_req_valid = 1'b1;
      S_OUT:   inst_valid     = 1'b1;
      S_ERR:   fetch_err      = 1'b1;
      default: ;
    endcase
  end

  assign imem_req_addr = pc_q;
  assign inst_o        = inst_q;
  assign inst_addr     = inst_addr_q;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Bench for ysyx_23060332_ifu: directed cycle table followed by randomized
// traffic checked against a transaction-level fetch model.
module tb_ysyx_23060332_ifu;

  localparam logic [31:0] RP   = 32'h8000_0000;
  localparam logic [31:0] RP4  = 32'h8000_0004;
  localparam logic [31:0] J100 = 32'h8000_0100;
  localparam logic [31:0] BADJ = 32'h8000_0102;
  localparam logic [31:0] Z    = 32'h0;
  localparam logic [31:0] D1   = 32'h0010_0093;
  localparam logic [31:0] D2   = 32'h0020_0113;
  localparam logic [31:0] D3   = 32'h0030_0193;
  localparam logic [31:0] STL  = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        fetch_err;

  always #5 clk = ~clk;

  ysyx_23060332_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_o         (inst_o),
    .inst_addr      (inst_addr),
    .jump_en        (jump_en),
    .jump_addr      (jump_addr),
    .fetch_err      (fetch_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    logic        rst, rdy, rspv;
    logic [31:0] rspd;
    logic        irdy, jen;
    logic [31:0] jaddr;
    logic        chk, erv;
    logic [31:0] era;
    logic        eiv;
    logic [31:0] eio, eia;
    logic        eerr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst_, rdy_, rspv_, input logic [31:0] rspd_,
                     input logic irdy_, jen_, input logic [31:0] jaddr_,
                     input logic chk_, erv_, input logic [31:0] era_, input logic eiv_,
                     input logic [31:0] eio_, eia_, input logic eerr_);
    vec_t v;
    v.rst = rst_; v.rdy = rdy_; v.rspv = rspv_; v.rspd = rspd_;
    v.irdy = irdy_; v.jen = jen_; v.jaddr = jaddr_;
    v.chk = chk_; v.erv = erv_; v.era = era_; v.eiv = eiv_;
    v.eio = eio_; v.eia = eia_; v.eerr = eerr_;
    vq.push_back(v);
  endtask

  // Random-phase model state.
  logic [31:0] m_pc, pend_addr, nxt, h_addr, h_io, h_ia;
  logic        m_err, got_rsp, pending, stale, post_rst, hold_req, hold_inst;
  int          delay, n_inst, sel;
  logic [98:0] got_v, exp_v;

  initial begin
    // Columns: rst rdy rspv rspd irdy jen jaddr | chk req_v req_addr inst_v inst_o inst_addr err
    add(1,0,0,Z,0,0,Z,        0,0,RP,0,Z,Z,0);
    add(1,0,0,Z,0,0,Z,        1,0,RP,0,Z,Z,0);       // reset state
    add(0,0,0,Z,0,0,Z,        1,0,RP,0,Z,Z,0);       // IDLE bubble
    for (int i = 0; i < 5; i++)
      add(0,0,0,Z,0,1,BADJ,   1,1,RP,0,Z,Z,0);       // REQ held, jump ignored
    add(0,1,0,Z,0,1,BADJ,     1,1,RP,0,Z,Z,0);       // accepted
    add(0,0,0,Z,1,1,BADJ,     1,0,RP,0,Z,Z,0);       // WAIT, no rsp yet
    add(0,0,1,D1,0,0,Z,       1,0,RP,0,Z,Z,0);       // rsp arrives
    add(0,0,0,Z,0,1,BADJ,     1,0,RP,1,D1,RP,0);     // OUT stalled
    add(0,1,1,32'hDEAD_BEEF,0,1,BADJ, 1,0,RP,1,D1,RP,0); // stray rsp ignored
    add(0,0,0,Z,0,1,BADJ,     1,0,RP,1,D1,RP,0);
    add(0,0,0,Z,0,1,BADJ,     1,0,RP,1,D1,RP,0);
    add(0,0,0,Z,1,0,BADJ,     1,0,RP,1,D1,RP,0);     // handshake, +4
    add(0,1,0,Z,0,0,Z,        1,1,RP4,0,D1,RP,0);
    add(0,0,1,D2,0,0,Z,       1,0,RP4,0,D1,RP,0);
    add(0,0,0,Z,1,1,J100,     1,0,RP4,1,D2,RP4,0);   // jump taken
    add(0,1,0,Z,0,0,Z,        1,1,J100,0,D2,RP4,0);
    add(0,0,1,D3,0,0,Z,       1,0,J100,0,D2,RP4,0);
    add(0,0,0,Z,1,1,BADJ,     1,0,J100,1,D3,J100,0); // misaligned jump
    add(0,1,1,32'h1111_1111,1,1,J100, 1,0,J100,0,D3,J100,1);
    add(0,1,1,32'h1111_1111,1,1,J100, 1,0,J100,0,D3,J100,1);
    add(1,1,1,32'h1111_1111,1,0,Z,    1,0,J100,0,D3,J100,1);
    add(0,0,0,Z,0,0,Z,        1,0,RP,0,Z,Z,0);       // IDLE after reset
    add(0,1,0,Z,0,0,Z,        1,1,RP,0,Z,Z,0);
    add(1,0,0,Z,0,0,Z,        1,0,RP,0,Z,Z,0);       // reset in WAIT
    add(0,0,1,STL,0,0,Z,      1,0,RP,0,Z,Z,0);       // stale rsp in IDLE
    add(0,0,1,STL,0,0,Z,      1,1,RP,0,Z,Z,0);       // stale rsp in REQ
    add(0,1,0,Z,0,0,Z,        1,1,RP,0,Z,Z,0);
    add(0,0,1,D1,0,0,Z,       1,0,RP,0,Z,Z,0);
    add(0,0,0,Z,1,0,Z,        1,0,RP,1,D1,RP,0);
    add(0,0,0,Z,0,0,Z,        1,1,RP4,0,D1,RP,0);

    @(negedge clk);
    foreach (vq[i]) begin
      if (vq[i].chk) begin
        got_v = {imem_req_valid, imem_req_addr, inst_valid, inst_o, inst_addr, fetch_err};
        exp_v = {vq[i].erv, vq[i].era, vq[i].eiv, vq[i].eio, vq[i].eia, vq[i].eerr};
        check($sformatf("vec%0d", i), 128'(got_v), 128'(exp_v));
      end
      rst            = vq[i].rst;
      imem_req_ready = vq[i].rdy;
      imem_rsp_valid = vq[i].rspv;
      imem_rsp_data  = vq[i].rspd;
      inst_ready     = vq[i].irdy;
      jump_en        = vq[i].jen;
      jump_addr      = vq[i].jaddr;
      @(negedge clk);
    end

    // Randomized traffic against the transaction-level model.
    hold_req = 1'b0; hold_inst = 1'b0; n_inst = 0; delay = 0;
    m_pc = RP; m_err = 1'b0; got_rsp = 1'b0; pending = 1'b0; stale = 1'b0; post_rst = 1'b0;
    pend_addr = '0; h_addr = '0; h_io = '0; h_ia = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) begin
        if (post_rst) begin
          check("post_reset_quiet", 128'({imem_req_valid, inst_valid, fetch_err}), 128'(0));
          post_rst = 1'b0;
        end else begin
          check("err_flag", 128'(fetch_err), 128'(m_err));
          if (m_err) check("err_quiet", 128'({imem_req_valid, inst_valid}), 128'(0));
          if (imem_req_valid) check("one_outstanding", 128'({pending, got_rsp}), 128'(0));
          if (hold_req)
            check("req_hold", 128'({imem_req_valid, imem_req_addr}), 128'({1'b1, h_addr}));
          if (hold_inst)
            check("inst_hold", 128'({inst_valid, inst_o, inst_addr}), 128'({1'b1, h_io, h_ia}));
        end
      end
      hold_req  = 1'b0;
      hold_inst = 1'b0;

      rst            = (cyc == 0) || ($urandom_range(0, m_err ? 7 : 99) == 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      inst_ready     = 1'($urandom_range(0, 1));
      jump_en        = ($urandom_range(0, 3) == 0);
      sel            = int'($urandom_range(0, 9));
      if (sel == 0)      jump_addr = RP + 32'($urandom_range(1, 3));
      else if (sel == 1) jump_addr = 32'hFFFF_FFFC;
      else               jump_addr = RP + (32'($urandom_range(0, 255)) << 2);

      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (stale) begin
        imem_rsp_valid = 1'b1;
        stale = 1'b0;
      end else if (pending) begin
        if (delay == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pending = 1'b0;
          got_rsp = 1'b1;
        end else begin
          delay--;
        end
      end else begin
        imem_rsp_valid = ($urandom_range(0, 7) == 0);
      end

      if (rst) begin
        stale    = pending;
        pending  = 1'b0;
        got_rsp  = 1'b0;
        m_pc     = RP;
        m_err    = 1'b0;
        post_rst = 1'b1;
      end else if (cyc > 0) begin
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", 128'(imem_req_addr), 128'(m_pc));
          pending   = 1'b1;
          pend_addr = m_pc;
          delay     = int'($urandom_range(0, 3));
        end else if (imem_req_valid) begin
          hold_req = 1'b1;
          h_addr   = imem_req_addr;
        end
        if (inst_valid && inst_ready) begin
          check("inst_after_rsp", 128'(got_rsp), 128'(1));
          check("inst_addr", 128'(inst_addr), 128'(m_pc));
          check("inst_data", 128'(inst_o), 128'(mem_word(m_pc)));
          got_rsp = 1'b0;
          n_inst++;
          nxt = jump_en ? jump_addr : m_pc + 32'd4;
          if (nxt[1:0] != 2'b00) m_err = 1'b1;
          else                   m_pc  = nxt;
        end else if (inst_valid) begin
          hold_inst = 1'b1;
          h_io      = inst_o;
          h_ia      = inst_addr;
        end
      end
      @(negedge clk);
    end
    check("progress", 128'(n_inst > 100), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
